trace_capture_buffer: RTL and testbench

Synthesizable, parametrised commit-trace capture unit for the RISC-V single-cycle and pipelined cores. It records one entry per retired instruction: cycle timestamp, PC, instruction and ALU result. Two modes: streaming FIFO, or PC-triggered ring capture with programmable post-trigger depth. Entries are read out oldest-first over a valid/ready port, which replaces per-cycle console monitoring with on-chip trace.

---
 rtl/trace_pkg.sv | 34 +++
 rtl/trace_capture_buffer_if.sv | 45 ++++
 rtl/trace_ram.sv | 30 +++
 rtl/trace_capture_buffer.sv | 192 +++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared types for the commit-trace capture unit.
//   trace_state_e  capture FSM states
//   trace_entry_t  one trace record {ts, pc, instr, result} at the default
//                  XLEN=32 / TS_W=16 layout (also the default RAM element type)
//   MODE_*         values of the mode input sampled on arm
//   is_capturing   true for states in which busy is reported
package trace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        ARMED,
        POST,
        DONE
    } trace_state_e;

    localparam int unsigned TRACE_XLEN = 32;
    localparam int unsigned TRACE_TS_W = 16;

    typedef struct packed {
        logic [TRACE_TS_W-1:0] ts;
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic [TRACE_XLEN-1:0] result;
    } trace_entry_t;

    localparam logic MODE_STREAM  = 1'b0;
    localparam logic MODE_TRIGGER = 1'b1;

    function automatic logic is_capturing(input trace_state_e s);
        return (s == STREAM) || (s == ARMED) || (s == POST);
    endfunction

endpackage

// File: rtl/trace_capture_buffer_if.sv
// trace_capture_buffer_if: bundles the retirement capture port, the control
// inputs and the show-ahead read port of trace_capture_buffer.
//   master: core/consumer side (drives cap_*, arm, mode, stop, trig_pc, rd_ready)
//   slave : trace buffer side (drives rd_*, count, triggered, overflow, busy)
interface trace_capture_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TS_W  = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             cap_valid;
    logic [XLEN-1:0]  cap_pc;
    logic [31:0]      cap_instr;
    logic [XLEN-1:0]  cap_result;
    logic             arm;
    logic             mode;
    logic             stop;
    logic [XLEN-1:0]  trig_pc;
    logic             rd_ready;
    logic             rd_valid;
    logic [TS_W-1:0]  rd_ts;
    logic [XLEN-1:0]  rd_pc;
    logic [31:0]      rd_instr;
    logic [XLEN-1:0]  rd_result;
    logic [CNT_W-1:0] count;
    logic             triggered;
    logic             overflow;
    logic             busy;

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_result,
        output arm, mode, stop, trig_pc, rd_ready,
        input  rd_valid, rd_ts, rd_pc, rd_instr, rd_result,
        input  count, triggered, overflow, busy
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_result,
        input  arm, mode, stop, trig_pc, rd_ready,
        output rd_valid, rd_ts, rd_pc, rd_instr, rd_result,
        output count, triggered, overflow, busy
    );

endinterface

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x entry_t storage for the trace buffer.
//   clk      write clock
//   we_i     write enable; waddr_i/wdata_i written at posedge
//   raddr_i  asynchronous read address; rdata_o = mem[raddr_i]
// Storage is intentionally not reset.
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  entry_t                   wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output entry_t                   rdata_o
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: commit-trace capture unit, one entry per retired
// instruction {ts, pc, instr, result}.
//   clk, rst  clock and asynchronous active-high reset
//   bus       trace_capture_buffer_if.slave:
//             cap_*      retirement sample (cap_valid qualifies)
//             arm/mode   start STREAM (FIFO) or TRIGGER (PC-triggered ring)
//             stop       freeze capture -> DONE
//             trig_pc    trigger address in TRIGGER mode
//             rd_*       show-ahead oldest entry, valid/ready handshake
//             count, triggered, overflow, busy   status
module trace_capture_buffer
    import trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8,
    parameter int unsigned TS_W      = 16
) (
    input logic                   clk,
    input logic                   rst,
    trace_capture_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);

    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] result;
    } entry_t;

    trace_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic             triggered_q, triggered_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             rd_valid_q, rd_valid_d;

    logic   we;
    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t rd_entry;

    assign wr_entry = '{ts: ts_q, pc: bus.cap_pc, instr: bus.cap_instr, result: bus.cap_result};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        post_cnt_d  = post_cnt_q;
        ts_d        = ts_q + 1'b1;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        we          = 1'b0;
        push        = 1'b0;
        pop         = rd_valid_q && bus.rd_ready;

        case (state_q)
            IDLE, DONE: begin
                if (bus.arm) begin
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                    post_cnt_d  = '0;
                    triggered_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = (bus.mode == MODE_TRIGGER) ? ARMED : STREAM;
                end else if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
            end

            STREAM: begin
                // A full FIFO still takes a push when the head leaves this cycle.
                push = bus.cap_valid && !bus.stop && ((count_q != FULL) || pop);
                if (bus.stop) begin
                    state_d = DONE;
                end else if (bus.cap_valid && !push) begin
                    overflow_d = 1'b1;
                end
                if (push) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end

            ARMED, POST: begin
                if (bus.stop) begin
                    state_d = DONE;
                end else if (bus.cap_valid) begin
                    // Ring write: once full, the oldest entry is overwritten.
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (count_q == FULL) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                    if (state_q == ARMED) begin
                        if (bus.cap_pc == bus.trig_pc) begin
                            triggered_d = 1'b1;
                            if (POST_TRIG == 0) begin
                                state_d = DONE;
                            end else begin
                                state_d    = POST;
                                post_cnt_d = POST_INIT;
                            end
                        end
                    end else begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == PTR_W'(1)) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        rd_valid_d = ((state_d == STREAM) || (state_d == DONE)) && (count_d != '0);
        busy_d     = is_capturing(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            post_cnt_q  <= '0;
            ts_q        <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            post_cnt_q  <= post_cnt_d;
            ts_q        <= ts_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    trace_ram #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_ts     = rd_entry.ts;
    assign bus.rd_pc     = rd_entry.pc;
    assign bus.rd_instr  = rd_entry.instr;
    assign bus.rd_result = rd_entry.result;
    assign bus.count     = count_q;
    assign bus.triggered = triggered_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Testbench for trace_capture_buffer: dut0 uses POST_TRIG=8, dut1 POST_TRIG=0.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_trace_capture_buffer;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TS_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_valid = 1'b0;
    logic [31:0] cap_pc = '0;
    logic [31:0] cap_instr = '0;
    logic [31:0] cap_result = '0;
    logic        mode = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        rd_ready = 1'b0;
    logic        arm0 = 1'b0;
    logic        arm1 = 1'b0;

    always #5 clk = ~clk;

    trace_capture_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) bus0 ();
    trace_capture_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W)) bus1 ();

    assign bus0.cap_valid = cap_valid;   assign bus1.cap_valid = cap_valid;
    assign bus0.cap_pc = cap_pc;         assign bus1.cap_pc = cap_pc;
    assign bus0.cap_instr = cap_instr;   assign bus1.cap_instr = cap_instr;
    assign bus0.cap_result = cap_result; assign bus1.cap_result = cap_result;
    assign bus0.mode = mode;             assign bus1.mode = mode;
    assign bus0.stop = stop;             assign bus1.stop = stop;
    assign bus0.trig_pc = trig_pc;       assign bus1.trig_pc = trig_pc;
    assign bus0.rd_ready = rd_ready;     assign bus1.rd_ready = rd_ready;
    assign bus0.arm = arm0;              assign bus1.arm = arm1;

    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(8), .TS_W(TS_W)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    trace_capture_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0), .TS_W(TS_W)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    // Reference cycle counter: value during a cycle is the timestamp of a capture in that cycle.
    logic [TS_W-1:0] tb_ts;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= '0;
        else     tb_ts <= tb_ts + 1'b1;
    end

    typedef struct {
        logic [TS_W-1:0] ts;
        logic [31:0]     pc;
        logic [31:0]     instr;
        logic [31:0]     result;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [TS_W+95:0] got, want;
    int checks = 0;
    int passed = 0;

    // Drive one retirement; optionally record it as an expected entry.
    task automatic retire(input logic [31:0] pc, input bit rec);
        exp_t n;
        cap_valid  = 1'b1;
        cap_pc     = pc;
        cap_instr  = {pc[15:0], 16'h0013};
        cap_result = pc * 3 + 32'h11;
        if (rec) begin
            n.ts = tb_ts; n.pc = pc; n.instr = cap_instr; n.result = cap_result;
            sb.push_back(n);
        end
    endtask

    // Ring model: keep only the newest DEPTH entries.
    task automatic ring_retire(input logic [31:0] pc);
        retire(pc, 1'b1);
        if (sb.size() > DEPTH) e = sb.pop_front();
    endtask

    task automatic do_arm(input bit which, input logic m, input logic [31:0] tp);
        sb.delete();
        mode = m; trig_pc = tp; cap_valid = 1'b0; stop = 1'b0;
        if (which) arm1 = 1'b1; else arm0 = 1'b1;
        @(negedge clk);
        arm0 = 1'b0; arm1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow} !== 9'd0)
            $display("FAIL reset_dut0: got cnt=%0d v=%b b=%b t=%b o=%b want all 0",
                     bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow);
        else passed++;
        checks++;
        if ({bus1.count, bus1.rd_valid, bus1.busy, bus1.triggered, bus1.overflow} !== 9'd0)
            $display("FAIL reset_dut1: got cnt=%0d v=%b b=%b want all 0", bus1.count, bus1.rd_valid, bus1.busy);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_stream_flow();
        do_arm(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus0.busy !== 1'b1 || bus0.rd_valid !== 1'b0)
            $display("FAIL flow_armed: got busy=%b rd_valid=%b want 1 0", bus0.busy, bus0.rd_valid);
        else passed++;
        rd_ready = 1'b1;
        retire(32'h0, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL flow_head: got rd_valid=%b want 1 (step %0d)", bus0.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus0.rd_ts, bus0.rd_pc, bus0.rd_instr, bus0.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL flow_head: got %h want %h", got, want);
                else passed++;
            end
            if (i < 16) retire(32'(i * 4), 1'b1);
            else cap_valid = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.count !== 5'd0 || bus0.overflow !== 1'b0)
            $display("FAIL flow_end: got v=%b cnt=%0d ovf=%b want 0 0 0", bus0.rd_valid, bus0.count, bus0.overflow);
        else passed++;
        stop = 1'b1; @(negedge clk); stop = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_stream_overflow();
        do_arm(1'b0, 1'b0, 32'h0);
        rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            retire(32'(i * 4), i < 16);
            @(negedge clk);
        end
        checks++;
        if (bus0.count !== 5'd16 || bus0.overflow !== 1'b1 || bus0.rd_valid !== 1'b1)
            $display("FAIL ovf_full: got cnt=%0d ovf=%b v=%b want 16 1 1", bus0.count, bus0.overflow, bus0.rd_valid);
        else passed++;
        // Push and pop together while full.
        checks++;
        e = sb.pop_front();
        if (bus0.rd_pc !== e.pc) $display("FAIL ovf_pushpop_head: got %h want %h", bus0.rd_pc, e.pc);
        else passed++;
        retire(32'h100, 1'b1);
        rd_ready = 1'b1;
        @(negedge clk);
        cap_valid = 1'b0; rd_ready = 1'b0;
        checks++;
        if (bus0.count !== 5'd16) $display("FAIL ovf_pushpop_count: got %0d want 16", bus0.count);
        else passed++;
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus0.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL ovf_drain: got rd_valid=%b want 1 (entry %0d)", bus0.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus0.rd_ts, bus0.rd_pc, bus0.rd_instr, bus0.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL ovf_drain: got %h want %h", got, want);
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.count !== 5'd0)
            $display("FAIL ovf_empty: got v=%b cnt=%0d want 0 0", bus0.rd_valid, bus0.count);
        else passed++;
        stop = 1'b1; @(negedge clk); stop = 1'b0; rd_ready = 1'b0;
    endtask

    // Trigger at 0x40 with an idle cycle after each post sample.
    task automatic test_trigger_post();
        do_arm(1'b0, 1'b1, 32'h40);
        for (int i = 0; i <= 16; i++) begin
            ring_retire(32'(i * 4));
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (bus0.rd_valid !== 1'b0 || bus0.count !== 5'd6)
                    $display("FAIL trig_armed: got v=%b cnt=%0d want 0 6", bus0.rd_valid, bus0.count);
                else passed++;
            end
        end
        checks++;
        if (bus0.triggered !== 1'b1 || bus0.busy !== 1'b1 || bus0.rd_valid !== 1'b0)
            $display("FAIL trig_seen: got t=%b b=%b v=%b want 1 1 0", bus0.triggered, bus0.busy, bus0.rd_valid);
        else passed++;
        for (int j = 1; j <= 8; j++) begin
            ring_retire(32'(32'h40 + j * 4));
            @(negedge clk);
            checks++;
            if (bus0.busy !== (j < 8)) $display("FAIL trig_post_busy: got %b want %b (post %0d)", bus0.busy, j < 8, j);
            else passed++;
            if (j < 8) begin cap_valid = 1'b0; @(negedge clk); end
        end
        cap_valid = 1'b0;
        checks++;
        if (bus0.count !== 5'd16 || bus0.rd_valid !== 1'b1)
            $display("FAIL trig_done: got cnt=%0d v=%b want 16 1", bus0.count, bus0.rd_valid);
        else passed++;
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus0.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL trig_drain: got rd_valid=%b want 1 (entry %0d)", bus0.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus0.rd_ts, bus0.rd_pc, bus0.rd_instr, bus0.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL trig_drain: got %h want %h", got, want);
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.rd_valid !== 1'b0) $display("FAIL trig_drained: got rd_valid=%b want 0", bus0.rd_valid);
        else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_trigger_zero();
        do_arm(1'b1, 1'b1, 32'h8);
        for (int i = 0; i < 3; i++) begin
            ring_retire(32'(i * 4));
            @(negedge clk);
        end
        retire(32'hC, 1'b0);
        checks++;
        if (bus1.busy !== 1'b0 || bus1.triggered !== 1'b1 || bus1.count !== 5'd3)
            $display("FAIL trig0_done: got b=%b t=%b cnt=%0d want 0 1 3", bus1.busy, bus1.triggered, bus1.count);
        else passed++;
        @(negedge clk);
        cap_valid = 1'b0;
        checks++;
        if (bus1.count !== 5'd3) $display("FAIL trig0_no_write: got cnt=%0d want 3", bus1.count);
        else passed++;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus1.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL trig0_drain: got rd_valid=%b want 1 (entry %0d)", bus1.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus1.rd_ts, bus1.rd_pc, bus1.rd_instr, bus1.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL trig0_drain: got %h want %h", got, want);
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus1.rd_valid !== 1'b0) $display("FAIL trig0_drained: got rd_valid=%b want 0", bus1.rd_valid);
        else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_stop_vs_trigger();
        do_arm(1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 4; i++) begin
            ring_retire(32'(i * 4));
            @(negedge clk);
        end
        retire(32'h10, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; cap_valid = 1'b0;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.triggered !== 1'b0 || bus0.count !== 5'd4)
            $display("FAIL stop_trig: got b=%b t=%b cnt=%0d want 0 0 4", bus0.busy, bus0.triggered, bus0.count);
        else passed++;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus0.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL stop_drain: got rd_valid=%b want 1 (entry %0d)", bus0.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus0.rd_ts, bus0.rd_pc, bus0.rd_instr, bus0.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL stop_drain: got %h want %h", got, want);
                else passed++;
            end
            @(negedge clk);
        end
        checks++;
        if (bus0.rd_valid !== 1'b0) $display("FAIL stop_drained: got rd_valid=%b want 0", bus0.rd_valid);
        else passed++;
        rd_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Reset during the post-trigger window.
        do_arm(1'b0, 1'b1, 32'h40);
        for (int i = 0; i <= 18; i++) begin
            ring_retire(32'(i * 4));
            @(negedge clk);
        end
        checks++;
        if (bus0.busy !== 1'b1 || bus0.triggered !== 1'b1)
            $display("FAIL rst_post_pre: got b=%b t=%b want 1 1", bus0.busy, bus0.triggered);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow} !== 9'd0)
            $display("FAIL rst_post: got cnt=%0d v=%b b=%b t=%b o=%b want all 0",
                     bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow);
        else passed++;
        @(negedge clk);
        rst = 1'b0; cap_valid = 1'b0;
        // Reset during a drain.
        do_arm(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            retire(32'(32'h80 + i * 4), 1'b1);
            @(negedge clk);
        end
        cap_valid = 1'b0; stop = 1'b1;
        @(negedge clk);
        stop = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus0.count !== 5'd3 || bus0.rd_valid !== 1'b1)
            $display("FAIL rst_drain_pre: got cnt=%0d v=%b want 3 1", bus0.count, bus0.rd_valid);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow} !== 9'd0)
            $display("FAIL rst_drain: got cnt=%0d v=%b b=%b t=%b o=%b want all 0",
                     bus0.count, bus0.rd_valid, bus0.busy, bus0.triggered, bus0.overflow);
        else passed++;
        @(negedge clk);
        rst = 1'b0; rd_ready = 1'b0;
        // Fresh capture after reset.
        do_arm(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            retire(32'(32'h200 + i * 4), 1'b1);
            @(negedge clk);
        end
        cap_valid = 1'b0;
        checks++;
        if (bus0.count !== 5'd3) $display("FAIL rst_recap_count: got %0d want 3", bus0.count);
        else passed++;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus0.rd_valid !== 1'b1 || sb.size() == 0) begin
                $display("FAIL rst_recap: got rd_valid=%b want 1 (entry %0d)", bus0.rd_valid, i);
            end else begin
                e = sb.pop_front();
                got  = {bus0.rd_ts, bus0.rd_pc, bus0.rd_instr, bus0.rd_result};
                want = {e.ts, e.pc, e.instr, e.result};
                if (got !== want) $display("FAIL rst_recap: got %h want %h", got, want);
                else passed++;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream_flow();
        test_stream_overflow();
        test_trigger_post();
        test_trigger_zero();
        test_stop_vs_trigger();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
